// File: rtl/pio_key_irq_host_pkg.sv
// Shared types and constants for the key PIO interrupt host.
package pio_key_irq_host_pkg;

  // Service sequencer states
  typedef enum logic [3:0] {
    ST_INIT,
    ST_IDLE,
    ST_MASK,
    ST_CAP_A,
    ST_CAP_D,
    ST_CLR,
    ST_LVL_A,
    ST_LVL_D,
    ST_EMIT
  } state_t;

  // Register map of the key PIO slave
  localparam logic [1:0] PIO_ADDR_DATA = 2'd0;
  localparam logic [1:0] PIO_ADDR_MASK = 2'd2;
  localparam logic [1:0] PIO_ADDR_CAP  = 2'd3;

  // Avalon data bus width
  localparam int BUS_W = 32;

endpackage

// File: rtl/pio_key_irq_host_if.sv
// Avalon-MM link between the key host (master) and the key PIO slave.
// A write is one cycle with chipselect=1, write_n=0. A read is two cycles
// (address then data phase) with chipselect=1, write_n=1; the slave registers
// readdata, so it is valid in the second cycle. Idle: chipselect=0, write_n=1.
interface pio_key_irq_host_if;
  logic [1:0]  m_address;
  logic        m_chipselect;
  logic        m_write_n;
  logic [31:0] m_writedata;
  logic [31:0] m_readdata;

  modport master (
    output m_address, m_chipselect, m_write_n, m_writedata,
    input  m_readdata
  );

  modport slave (
    input  m_address, m_chipselect, m_write_n, m_writedata,
    output m_readdata
  );
endinterface

// File: rtl/pio_key_irq_host.sv
// Key PIO interrupt host: programs the irq mask, services each irq by reading
// and clearing edge_capture, samples the key levels, and emits one event.
// Event stream: an event transfers on a cycle where evt_valid && evt_ready;
// evt_valid is never withdrawn and evt_edges/evt_level stay stable until then.
module pio_key_irq_host
  import pio_key_irq_host_pkg::*;
#(
  parameter int               WIDTH     = 4,
  parameter logic [WIDTH-1:0] MASK_INIT = {WIDTH{1'b1}},
  parameter int               CNT_W     = 16
) (
  input  logic               clk,
  input  logic               reset_n,
  pio_key_irq_host_if.master bus,
  input  logic               irq_in,
  input  logic               enable,
  input  logic               mask_wr,
  input  logic [WIDTH-1:0]   mask_val,
  output logic               evt_valid,
  input  logic               evt_ready,
  output logic [WIDTH-1:0]   evt_edges,
  output logic [WIDTH-1:0]   evt_level,
  output logic [CNT_W-1:0]   evt_count,
  output logic               busy,
  output state_t             state_o
);

  state_t             state_q;
  logic [1:0]         addr_q;
  logic               cs_q;
  logic               wr_n_q;
  logic [BUS_W-1:0]   wdata_q;
  logic               evt_valid_q;
  logic [WIDTH-1:0]   evt_edges_q;
  logic [WIDTH-1:0]   evt_level_q;
  logic [CNT_W-1:0]   evt_count_q;
  logic               busy_q;
  logic               holdoff_q;
  logic               mask_pend_q;
  logic [WIDTH-1:0]   mask_val_q;

  // Only the low key bits of the slave readback carry information
  logic [WIDTH-1:0]   rd_bits;
  logic               unused_rd_hi;
  assign rd_bits      = bus.m_readdata[WIDTH-1:0];
  assign unused_rd_hi = ^bus.m_readdata[BUS_W-1:WIDTH];

  function automatic logic [BUS_W-1:0] pad(input logic [WIDTH-1:0] v);
    pad = {{(BUS_W-WIDTH){1'b0}}, v};
  endfunction

  // Sequencer: bus outputs are registered together with the state they belong
  // to, so each bus cycle lines up with its state (the INIT mask write lands in
  // the first IDLE cycle because the reset bus value must be idle).
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_INIT;
      addr_q      <= PIO_ADDR_DATA;
      cs_q        <= 1'b0;
      wr_n_q      <= 1'b1;
      wdata_q     <= '0;
      evt_valid_q <= 1'b0;
      evt_edges_q <= '0;
      evt_level_q <= '0;
      evt_count_q <= '0;
      busy_q      <= 1'b1;
      holdoff_q   <= 1'b0;
      mask_pend_q <= 1'b0;
      mask_val_q  <= '0;
    end else begin
      cs_q   <= 1'b0;
      wr_n_q <= 1'b1;
      case (state_q)
        ST_INIT: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
          addr_q  <= PIO_ADDR_MASK;
          cs_q    <= 1'b1;
          wr_n_q  <= 1'b0;
          wdata_q <= pad(MASK_INIT);
        end
        ST_IDLE: begin
          // One-cycle holdoff lets a just-cleared irq fall before we look again
          holdoff_q <= 1'b0;
          if (mask_pend_q) begin
            state_q     <= ST_MASK;
            busy_q      <= 1'b1;
            addr_q      <= PIO_ADDR_MASK;
            cs_q        <= 1'b1;
            wr_n_q      <= 1'b0;
            wdata_q     <= pad(mask_val_q);
            mask_pend_q <= 1'b0;
          end else if (enable && irq_in && !holdoff_q) begin
            state_q <= ST_CAP_A;
            busy_q  <= 1'b1;
            addr_q  <= PIO_ADDR_CAP;
            cs_q    <= 1'b1;
          end
        end
        ST_MASK: begin
          state_q   <= ST_IDLE;
          busy_q    <= 1'b0;
          holdoff_q <= 1'b1;
        end
        ST_CAP_A: begin
          state_q <= ST_CAP_D;
          cs_q    <= 1'b1;
        end
        ST_CAP_D: begin
          if (rd_bits == '0) begin
            // Spurious irq: nothing captured, nothing to clear
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
          end else begin
            // Clear only what we saw; later edges on other bits stay pending
            state_q     <= ST_CLR;
            cs_q        <= 1'b1;
            wr_n_q      <= 1'b0;
            wdata_q     <= pad(rd_bits);
            evt_edges_q <= rd_bits;
          end
        end
        ST_CLR: begin
          state_q <= ST_LVL_A;
          addr_q  <= PIO_ADDR_DATA;
          cs_q    <= 1'b1;
        end
        ST_LVL_A: begin
          state_q <= ST_LVL_D;
          cs_q    <= 1'b1;
        end
        ST_LVL_D: begin
          state_q     <= ST_EMIT;
          evt_level_q <= rd_bits;
          evt_valid_q <= 1'b1;
        end
        ST_EMIT: begin
          if (evt_ready) begin
            state_q     <= ST_IDLE;
            busy_q      <= 1'b0;
            holdoff_q   <= 1'b1;
            evt_valid_q <= 1'b0;
            evt_count_q <= evt_count_q + CNT_W'(1);
          end
        end
        default: begin
          state_q <= ST_INIT;
          busy_q  <= 1'b1;
        end
      endcase
      // A mask request is remembered in any state; a new one overrides
      if (mask_wr) begin
        mask_pend_q <= 1'b1;
        mask_val_q  <= mask_val;
      end
    end
  end

  assign bus.m_address    = addr_q;
  assign bus.m_chipselect = cs_q;
  assign bus.m_write_n    = wr_n_q;
  assign bus.m_writedata  = wdata_q;
  assign evt_valid        = evt_valid_q;
  assign evt_edges        = evt_edges_q;
  assign evt_level        = evt_level_q;
  assign evt_count        = evt_count_q;
  assign busy             = busy_q;
  assign state_o          = state_q;

endmodule
